// File: rtl/vedic4x4_pipe.sv
// Two-stage pipelined 4x4 Urdhva-Tiryakbhyam multiplier with valid/ready on both sides.
// Stage 1 registers four 2x2 partial products; stage 2 registers the combined 8-bit product.
module vedic4x4_pipe (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] p,
    output logic       out_valid,
    input  logic       out_ready
);

    // 2x2 Vedic cell: vertical AND terms, crosswise sum through two half adders.
    function automatic logic [3:0] vedic2x2(input logic [1:0] x, input logic [1:0] y);
        logic cross_s;
        logic cross_c;
        logic top;
        cross_s = (x[1] & y[0]) ^ (x[0] & y[1]);
        cross_c = (x[1] & y[0]) & (x[0] & y[1]);
        top     = x[1] & y[1];
        return {top & cross_c, top ^ cross_c, cross_s, x[0] & y[0]};
    endfunction

    logic [3:0] pp_d [4];
    logic [3:0] pp_q [4];
    logic       s1_v_q;
    logic [7:0] p_q;
    logic       out_valid_q;

    logic       s2_adv;
    logic       accept;
    logic [4:0] mid_d;
    logic [4:0] t_d;
    logic [3:0] hi_d;
    logic [7:0] p_d;

    // Cell gi multiplies a-half (gi%2) by b-half (gi/2): q0, q1, q2, q3.
    for (genvar gi = 0; gi < 4; gi++) begin : g_cell
        assign pp_d[gi] = vedic2x2(a[2*(gi%2) +: 2], b[2*(gi/2) +: 2]);
    end

    assign s2_adv   = s1_v_q && (!out_valid_q || out_ready);
    assign in_ready = !s1_v_q || s2_adv;
    assign accept   = in_valid && in_ready;

    // Widths are trimmed to the largest reachable value, so dropped carries are always zero.
    assign mid_d = {1'b0, pp_q[1]} + {1'b0, pp_q[2]};
    assign t_d   = {3'b000, pp_q[0][3:2]} + mid_d;
    assign hi_d  = pp_q[3] + {1'b0, t_d[4:2]};
    assign p_d   = {hi_d, t_d[1:0], pp_q[0][1:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                pp_q[i] <= 4'h0;
            end
            s1_v_q      <= 1'b0;
            p_q         <= 8'h00;
            out_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                for (int i = 0; i < 4; i++) begin
                    pp_q[i] <= pp_d[i];
                end
            end
            if (in_ready) begin
                s1_v_q <= accept;
            end
            if (s2_adv) begin
                p_q         <= p_d;
                out_valid_q <= 1'b1;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign p         = p_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_vedic4x4_pipe.sv
// Directed bench for vedic4x4_pipe: reset, single op, full 256-pair stream,
// backpressure, random valid/ready with scoreboard, and reset mid-stream.
module tb_vedic4x4_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] p;
    logic       out_valid;
    logic       out_ready;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q [$];
    logic [7:0] log_q [$];
    logic       stall_q = 1'b0;
    logic [7:0] hold_p  = 8'h00;

    vedic4x4_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .p         (p),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check held output under stall, score transfers, advance.
    task automatic cyc(input logic v, input logic [3:0] aa, input logic [3:0] bb, input logic ordy);
        logic       acc;
        logic       outx;
        logic [7:0] e;
        in_valid  = v;
        a         = aa;
        b         = bb;
        out_ready = ordy;
        #1;
        if (stall_q) begin
            chk("hold_p", 32'(p), 32'(hold_p));
            chk("hold_valid", 32'(out_valid), 32'h1);
        end
        acc  = in_valid && in_ready;
        outx = out_valid && out_ready;
        if (outx) begin
            chk("spurious_out", 32'(exp_q.size() == 0), 32'h0);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("product", 32'(p), 32'(e));
                $display("xfer out p=%0d expected=%0d", p, e);
            end
            log_q.push_back(p);
        end
        if (acc) begin
            exp_q.push_back({4'h0, aa} * {4'h0, bb});
        end
        stall_q = out_valid && !out_ready;
        hold_p  = p;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ls;
        logic [7:0] ab;

        // Reset held two cycles with in_valid asserted
        rst_n = 1'b0; in_valid = 1'b1; a = 4'hF; b = 4'hF; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_p", 32'(p), 32'h00);
        rst_n = 1'b1; in_valid = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'h1);

        // Single op 15*15, two-cycle latency, valid for exactly one cycle
        cyc(1'b1, 4'hF, 4'hF, 1'b1);
        chk("single_lat1_valid", 32'(out_valid), 32'h0);
        cyc(1'b0, 4'h0, 4'h0, 1'b1);
        chk("single_valid", 32'(out_valid), 32'h1);
        chk("single_p", 32'(p), 32'hE1);
        cyc(1'b0, 4'h0, 4'h0, 1'b1);
        chk("single_valid_drop", 32'(out_valid), 32'h0);

        // All 256 pairs back-to-back
        ls = log_q.size();
        for (int i = 0; i < 256; i++) begin
            ab = 8'(i);
            chk("stream_in_ready", 32'(in_ready), 32'h1);
            if (i >= 2) chk("stream_no_gap", 32'(out_valid), 32'h1);
            cyc(1'b1, ab[7:4], ab[3:0], 1'b1);
        end
        cyc(1'b0, 4'h0, 4'h0, 1'b1);
        cyc(1'b0, 4'h0, 4'h0, 1'b1);
        chk("stream_count", 32'(log_q.size() - ls), 32'd256);
        chk("stream_drained", 32'(exp_q.size()), 32'd0);

        // Backpressure: 3*5, 7*9, 15*2 with out_ready low from the first output
        ls = log_q.size();
        cyc(1'b1, 4'd3, 4'd5, 1'b0);
        cyc(1'b1, 4'd7, 4'd9, 1'b0);
        chk("bp_valid", 32'(out_valid), 32'h1);
        chk("bp_p", 32'(p), 32'h0F);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 4'd15, 4'd2, 1'b0);
            chk("bp_in_ready", 32'(in_ready), 32'h0);
        end
        cyc(1'b1, 4'd15, 4'd2, 1'b1);
        repeat (4) cyc(1'b0, 4'h0, 4'h0, 1'b1);
        chk("bp_count", 32'(log_q.size() - ls), 32'd3);
        if (log_q.size() >= ls + 3) begin
            chk("bp_out0", 32'(log_q[ls]), 32'd15);
            chk("bp_out1", 32'(log_q[ls + 1]), 32'd63);
            chk("bp_out2", 32'(log_q[ls + 2]), 32'd30);
        end

        // Random valid/ready with scoreboard and stability checks
        for (int i = 0; i < 2000; i++) begin
            cyc(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end
        repeat (4) cyc(1'b0, 4'h0, 4'h0, 1'b1);
        chk("rand_drained", 32'(exp_q.size()), 32'd0);

        // Reset with both stages full
        cyc(1'b1, 4'd4, 4'd4, 1'b0);
        cyc(1'b1, 4'd5, 4'd5, 1'b0);
        chk("mid_full_ready", 32'(in_ready), 32'h0);
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'h1);
        exp_q.delete();
        stall_q = 1'b0;
        rst_n = 1'b1;
        ls = log_q.size();
        cyc(1'b1, 4'd2, 4'd3, 1'b1);
        repeat (3) cyc(1'b0, 4'h0, 4'h0, 1'b1);
        chk("mid_count", 32'(log_q.size() - ls), 32'd1);
        if (log_q.size() > ls) chk("mid_first_p", 32'(log_q[ls]), 32'h06);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
